servo_pwm_gen: RTL and testbench



---
 rtl/servo_pwm_gen.sv | 151 +++++++++++++++
 tb/tb_servo_pwm_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: 50 Hz hobby-servo pulse generator driven by an 8-bit angle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   angle        requested angle in degrees (clamped to MAX_ANGLE)
//   enable       pulse enable, sampled at the start of each frame
//   pwm_out      registered servo control line
//   frame_start  one-cycle strobe on the first clk of each frame
//   width_us     pulse width in effect for the current frame
//   clamped      high for a frame whose sampled angle exceeded MAX_ANGLE
//
// Optional build macro SERVO_SLEW_LIMIT_EN: the width moves toward its target
// by at most SLEW_US per frame instead of jumping straight to it.
module servo_pwm_gen #(
    parameter int CLK_HZ    = 50000000,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int MAX_ANGLE = 180,
    parameter int SLEW_US   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  angle,
    input  logic        enable,
    output logic        pwm_out,
    output logic        frame_start,
    output logic [11:0] width_us,
    output logic        clamped
);
    localparam int DIV   = CLK_HZ / 1000000;
    localparam int PRW   = $clog2(DIV);
    localparam int UW    = $clog2(FRAME_US);
    localparam int RANGE = MAX_US - MIN_US;
    localparam int PNEED = $clog2(MAX_ANGLE * RANGE + 1);
    localparam int PW    = PNEED > 19 ? PNEED : 19;
    localparam int RMW   = $clog2(MAX_ANGLE + 1);
    localparam int CW    = $clog2(PW);
    localparam logic [11:0] RST_W = 12'((MIN_US + MAX_US) / 2);
`ifdef SERVO_SLEW_LIMIT_EN
    localparam int STEP_LIM = SLEW_US;
`else
    // A bound no smaller than the whole range lets every move land in one frame.
    localparam int STEP_LIM = SLEW_US > RANGE ? SLEW_US : RANGE;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;
    state_t r_state, w_next;

    logic [PRW-1:0] r_pre;
    logic [UW-1:0]  r_us;
    logic           r_en, r_pwm, r_clamped;
    logic [11:0]    r_width, r_pending, r_quo;
    logic [7:0]     r_angle_s;
    logic [PW-1:0]  r_num;
    logic [RMW-1:0] r_rem;
    logic [CW-1:0]  r_cnt;
    logic           w_tick, w_fs, w_over, w_ge, w_up;
    logic [RMW:0]   w_sh;
    logic [11:0]    w_target, w_diff, w_step;

    assign w_tick      = r_pre == PRW'(DIV - 1);
    assign w_fs        = r_pre == '0 && r_us == '0;
    // Counters sit at zero during reset, so the strobe is masked until release.
    assign frame_start = w_fs && !rst;
    assign w_over      = 32'(angle) > MAX_ANGLE;
    assign pwm_out     = r_pwm;
    assign width_us    = r_width;
    assign clamped     = r_clamped;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_us  <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick)
                r_us <= (r_us == UW'(FRAME_US - 1)) ? '0 : r_us + 1'b1;
        end
    end

    // Pulse is high for positions 1..width*DIV of the frame, i.e. while the
    // current position is below width*DIV, which reduces to r_us < width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_pwm     <= 1'b0;
            r_clamped <= 1'b0;
            r_width   <= RST_W;
            r_angle_s <= '0;
        end else begin
            r_pwm <= w_fs ? (enable && r_pending != '0) : (r_en && 32'(r_us) < 32'(r_width));
            if (w_fs) begin
                r_en      <= enable;
                r_width   <= r_pending;
                r_clamped <= w_over;
                r_angle_s <= w_over ? 8'(MAX_ANGLE) : angle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_fs ? S_LOAD : S_IDLE;
            S_LOAD:  w_next = S_DIV;
            S_DIV:   w_next = r_cnt == '0 ? S_DONE : S_DIV;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Restoring division of angle_s*RANGE by MAX_ANGLE, one quotient bit per
    // cycle; the quotient never exceeds RANGE, so 12 bits hold it.
    assign w_sh     = {r_rem, r_num[PW-1]};
    assign w_ge     = w_sh >= (RMW+1)'(MAX_ANGLE);
    assign w_target = 12'(MIN_US) + r_quo;
    assign w_up     = w_target > r_pending;
    assign w_diff   = w_up ? w_target - r_pending : r_pending - w_target;
    assign w_step   = 32'(w_diff) > STEP_LIM ? 12'(STEP_LIM) : w_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_pending <= RST_W;
        end else if (r_state == S_LOAD) begin
            r_num <= PW'(r_angle_s) * PW'(RANGE);
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= CW'(PW - 1);
        end else if (r_state == S_DIV) begin
            r_num <= r_num << 1;
            r_rem <= RMW'(w_ge ? w_sh - (RMW+1)'(MAX_ANGLE) : w_sh);
            r_quo <= {r_quo[10:0], w_ge};
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == S_DONE) begin
            r_pending <= w_up ? r_pending + w_step : r_pending - w_step;
        end
    end
endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: directed self-checking bench for servo_pwm_gen (scaled timing).
//
// Scaled parameters: DIV=2, frame 300 us (600 clk), pulse 100..200 us.
// Expected widths: angle 90->150, 0->100, 180->200, 45->125, 100->155.
module tb_servo_pwm_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  angle = 8'd90;
    logic        enable = 1'b1;
    logic        pwm_out, frame_start, clamped;
    logic [11:0] width_us;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    servo_pwm_gen #(
        .CLK_HZ(2000000), .FRAME_US(300), .MIN_US(100), .MAX_US(200),
        .MAX_ANGLE(180), .SLEW_US(20)
    ) dut (
        .clk(clk), .rst(rst), .angle(angle), .enable(enable),
        .pwm_out(pwm_out), .frame_start(frame_start),
        .width_us(width_us), .clamped(clamped)
    );

    task automatic wait_fs();
        int n = 0;
        while (frame_start !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (frame_start !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_fs: frame_start=%b after %0d cycles, expected 1", frame_start, n);
        end
    endtask

    // Starts at a frame_start negedge, ends at the next one.
    task automatic run_frame(input int tog_at, input logic tog_val,
                             output int high, output int period,
                             output logic [11:0] w, output logic c);
        high = 0;
        period = 0;
        w = '0;
        c = 1'b0;
        do begin
            @(negedge clk);
            period++;
            if (period == 1) begin
                w = width_us;
                c = clamped;
            end
            if (pwm_out) high++;
            if (period == tog_at) enable = tog_val;
        end while (frame_start !== 1'b1 && period < 2000);
    endtask

    task automatic test_reset();
        int h, p;
        logic [11:0] w;
        logic c;
        repeat (3) @(negedge clk);
        checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL rst_pwm: got %b expected 0", pwm_out); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL rst_fs: got %b expected 0", frame_start); end
        checks++; if (clamped !== 1'b0) begin failures++; $display("FAIL rst_clamped: got %b expected 0", clamped); end
        checks++; if (width_us !== 12'd150) begin failures++; $display("FAIL rst_width: got %0d expected 150", width_us); end
        rst = 1'b0;
        #1;
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL rel_fs: got %b expected 1", frame_start); end
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (w !== 12'd150) begin failures++; $display("FAIL f0_width: got %0d expected 150", w); end
        checks++; if (p != 600) begin failures++; $display("FAIL f0_period: got %0d expected 600", p); end
        checks++; if (h != 300) begin failures++; $display("FAIL f0_high: got %0d expected 300", h); end
        run_frame(-1, 1'b1, h, p, w, c);
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (h != 300) begin failures++; $display("FAIL f2_high: got %0d expected 300", h); end
        checks++; if (p != 600) begin failures++; $display("FAIL f2_period: got %0d expected 600", p); end
    endtask

    task automatic test_angle_sweep();
        int a_tab[3] = '{0, 180, 45};
        int e_tab[3] = '{100, 200, 125};
        int prev = 150;
        int h, p;
        logic [11:0] w;
        logic c;
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(negedge clk);
            angle = 8'(a_tab[i]);
            wait_fs();
            run_frame(-1, 1'b1, h, p, w, c);
            checks++; if (32'(w) != prev) begin failures++; $display("FAIL sweep_lat[%0d]: got %0d expected %0d", i, w, prev); end
            run_frame(-1, 1'b1, h, p, w, c);
            checks++; if (32'(w) != e_tab[i]) begin failures++; $display("FAIL sweep_width[%0d]: got %0d expected %0d", i, w, e_tab[i]); end
            checks++; if (h != 2 * e_tab[i]) begin failures++; $display("FAIL sweep_high[%0d]: got %0d expected %0d", i, h, 2 * e_tab[i]); end
            prev = e_tab[i];
        end
    endtask

    task automatic test_clamp();
        int h, p;
        logic [11:0] w;
        logic c;
        repeat (3) @(negedge clk);
        angle = 8'd200;
        wait_fs();
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL clamp_on: got %b expected 1", c); end
        checks++; if (w !== 12'd125) begin failures++; $display("FAIL clamp_lat: got %0d expected 125", w); end
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (w !== 12'd200) begin failures++; $display("FAIL clamp_width: got %0d expected 200", w); end
        checks++; if (h != 400) begin failures++; $display("FAIL clamp_high: got %0d expected 400", h); end
        repeat (3) @(negedge clk);
        angle = 8'd100;
        wait_fs();
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL clamp_off: got %b expected 0", c); end
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (w !== 12'd155) begin failures++; $display("FAIL a100_width: got %0d expected 155", w); end
        checks++; if (h != 310) begin failures++; $display("FAIL a100_high: got %0d expected 310", h); end
    endtask

    task automatic test_enable();
        int h, p;
        logic [11:0] w;
        logic c;
        run_frame(5, 1'b0, h, p, w, c);
        checks++; if (h != 310) begin failures++; $display("FAIL en_drop_mid: got %0d expected 310", h); end
        run_frame(400, 1'b1, h, p, w, c);
        checks++; if (h != 0) begin failures++; $display("FAIL en_off_frame: got %0d expected 0", h); end
        checks++; if (w !== 12'd155) begin failures++; $display("FAIL en_off_width: got %0d expected 155", w); end
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (h != 310) begin failures++; $display("FAIL en_back: got %0d expected 310", h); end
    endtask

    task automatic test_reset_mid_pulse();
        int h, p;
        logic [11:0] w;
        logic c;
        repeat (20) @(negedge clk);
        checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL pre_rst_pwm: got %b expected 1", pwm_out); end
        rst = 1'b1;
        #1;
        checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL mid_rst_pwm: got %b expected 0", pwm_out); end
        checks++; if (width_us !== 12'd150) begin failures++; $display("FAIL mid_rst_width: got %0d expected 150", width_us); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL mid_rst_fs: got %b expected 0", frame_start); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL rel2_fs: got %b expected 1", frame_start); end
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (w !== 12'd150) begin failures++; $display("FAIL rel2_width: got %0d expected 150", w); end
        checks++; if (p != 600) begin failures++; $display("FAIL rel2_period: got %0d expected 600", p); end
        checks++; if (h != 300) begin failures++; $display("FAIL rel2_high: got %0d expected 300", h); end
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (w !== 12'd155) begin failures++; $display("FAIL rel2_next_width: got %0d expected 155", w); end
    endtask

    task automatic test_slew();
        int h, p;
        logic [11:0] w;
        logic c;
        repeat (3) @(negedge clk);
        angle = 8'd0;
        wait_fs();
        run_frame(-1, 1'b1, h, p, w, c);
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (w !== 12'd100) begin failures++; $display("FAIL slew_low: got %0d expected 100", w); end
        repeat (3) @(negedge clk);
        angle = 8'd180;
        wait_fs();
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (w !== 12'd100) begin failures++; $display("FAIL slew_hold: got %0d expected 100", w); end
        run_frame(-1, 1'b1, h, p, w, c);
        checks++; if (w !== 12'd200) begin failures++; $display("FAIL slew_jump: got %0d expected 200", w); end
        checks++; if (h != 400) begin failures++; $display("FAIL slew_high: got %0d expected 400", h); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time %0t reached, expected run to end earlier", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_angle_sweep();
        test_clamp();
        test_enable();
        test_reset_mid_pulse();
        test_slew();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
